hv_classifier: RTL and testbench

Associative-memory search stage directly downstream of the encoder. It captures the encoded hypervector when the encoder signals completion. It then scores the vector against NUM_CLASSES stored class hypervectors, one class per clock, using sparse overlap (popcount of bitwise AND). It returns the best-matching class index and its score with a one-cycle done pulse.

---
 rtl/hdc_pkg.sv | 28 ++
 rtl/hv_classifier_if.sv | 24 ++
 rtl/overlap_counter.sv | 12 +
 rtl/hv_classifier.sv | 109 ++++++++++
 tb/tb_hv_classifier.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hdc_pkg.sv
// Shared hyperdimensional-computing constants, types and helpers for the
// encoder and classifier stages.
package hdc_pkg;

    localparam int HV_DIM      = 80;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = $clog2(NUM_CLASSES);
    localparam int SCORE_W     = $clog2(HV_DIM + 1);

    typedef logic [HV_DIM-1:0] hv_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cls_state_t;

    // SCORE_W is sized for HV_DIM, so the running count cannot wrap.
    function automatic logic [SCORE_W-1:0] popcount_hv(input hv_t v);
        logic [SCORE_W-1:0] cnt;
        cnt = {SCORE_W{1'b0}};
        for (int i = 0; i < HV_DIM; i++) begin
            cnt = cnt + {{(SCORE_W-1){1'b0}}, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/hv_classifier_if.sv
// Request/result bundle between the encoder side and the classifier.
interface hv_classifier_if;
    import hdc_pkg::*;

    logic                 en;
    logic                 start_classify;
    hv_t                  encoded_hv;
    hv_t                  class_hvs [0:NUM_CLASSES-1];
    logic                 busy;
    logic                 classify_done;
    logic [CLASS_W-1:0]   pred_class;
    logic [SCORE_W-1:0]   best_score;

    modport master (
        output en, start_classify, encoded_hv, class_hvs,
        input  busy, classify_done, pred_class, best_score
    );

    modport slave (
        input  en, start_classify, encoded_hv, class_hvs,
        output busy, classify_done, pred_class, best_score
    );

endinterface

// File: rtl/overlap_counter.sv
// Sparse overlap score: number of bit positions set in both vectors.
module overlap_counter
    import hdc_pkg::*;
(
    input  hv_t                a,
    input  hv_t                b,
    output logic [SCORE_W-1:0] score
);

    assign score = popcount_hv(a & b);

endmodule

// File: rtl/hv_classifier.sv
// Associative-memory search: scans one class hypervector per clock and keeps
// the best strict-greater overlap, so ties resolve to the lowest index.
module hv_classifier
    import hdc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    hv_classifier_if.slave  bus
);

    localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);
    localparam logic [CLASS_W-1:0] IDX_ONE  = {{(CLASS_W-1){1'b0}}, 1'b1};

    cls_state_t           state_r;
    cls_state_t           state_s;
    logic [CLASS_W-1:0]   idx_r;
    logic [CLASS_W-1:0]   idx_s;
    hv_t                  hv_q_r;
    hv_t                  hv_q_s;
    logic [CLASS_W-1:0]   pred_r;
    logic [CLASS_W-1:0]   pred_s;
    logic [SCORE_W-1:0]   best_r;
    logic [SCORE_W-1:0]   best_s;
    logic                 busy_r;
    logic                 done_r;
    hv_t                  class_sel_s;
    logic [SCORE_W-1:0]   score_s;

    assign class_sel_s = bus.class_hvs[idx_r];

    overlap_counter u_overlap (
        .a     (hv_q_r),
        .b     (class_sel_s),
        .score (score_s)
    );

    // Next-state and datapath update; everything holds while en is low.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        hv_q_s  = hv_q_r;
        pred_s  = pred_r;
        best_s  = best_r;
        if (bus.en) begin
            case (state_r)
                IDLE: begin
                    if (bus.start_classify) begin
                        hv_q_s  = bus.encoded_hv;
                        idx_s   = {CLASS_W{1'b0}};
                        best_s  = {SCORE_W{1'b0}};
                        pred_s  = {CLASS_W{1'b0}};
                        state_s = SCAN;
                    end else begin
                        state_s = IDLE;
                    end
                end
                SCAN: begin
                    if ((idx_r == {CLASS_W{1'b0}}) || (score_s > best_r)) begin
                        best_s = score_s;
                        pred_s = idx_r;
                    end else begin
                        best_s = best_r;
                        pred_s = pred_r;
                    end
                    if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            idx_r   <= {CLASS_W{1'b0}};
            hv_q_r  <= {HV_DIM{1'b0}};
            pred_r  <= {CLASS_W{1'b0}};
            best_r  <= {SCORE_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            hv_q_r  <= hv_q_s;
            pred_r  <= pred_s;
            best_r  <= best_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == DONE);
        end
    end

    assign bus.busy          = busy_r;
    assign bus.classify_done = done_r;
    assign bus.pred_class    = pred_r;
    assign bus.best_score    = best_r;

endmodule

// File: tb/tb_hv_classifier.sv
// Table-driven, scoreboard-checked bench for hv_classifier.
module tb_hv_classifier;
    import hdc_pkg::*;

    typedef logic [CLASS_W+SCORE_W-1:0] res_t;

    typedef struct packed {
        hv_t                                enc;
        logic [NUM_CLASSES-1:0][HV_DIM-1:0] cls;
        logic [CLASS_W-1:0]                 pred;
        logic [SCORE_W-1:0]                 score;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hv_classifier_if bus ();

    hv_classifier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    vec_t vecs [6];
    res_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic hv_t rand_hv();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        return r[HV_DIM-1:0];
    endfunction

    // Independent reference: best strict-greater overlap across all classes.
    function automatic res_t ref_result(input vec_t v);
        int best;
        int pred;
        int s;
        hv_t c;
        best = 0;
        pred = 0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            c = v.cls[i];
            s = $countones(v.enc & c);
            if (i == 0 || s > best) begin
                best = s;
                pred = i;
            end
        end
        return {CLASS_W'(pred), SCORE_W'(best)};
    endfunction

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < NUM_CLASSES; i++) begin
            bus.class_hvs[i] = v.cls[i];
        end
        bus.encoded_hv = v.enc;
    endtask

    // stall_at > 0: drop en for 3 cycles at that point, then pulse start in SCAN.
    task automatic run_vec(input vec_t v, input string name, input int stall_at, input int exp_lat);
        int   cnt;
        int   w;
        res_t r;
        w = 0;
        while (bus.busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk({name, "_idle_before"}, {31'd0, bus.busy}, 32'd0);
        load_vec(v);
        bus.start_classify = 1'b1;
        sb_q.push_back({v.pred, v.score});
        @(negedge clk);
        bus.start_classify = 1'b0;
        cnt = 1;
        chk({name, "_busy_in_scan"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.classify_done && cnt < 40) begin
            if (cnt == stall_at) begin
                bus.en = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    cnt++;
                end
                bus.en = 1'b1;
                bus.start_classify = 1'b1;
                @(negedge clk);
                cnt++;
                bus.start_classify = 1'b0;
            end else begin
                @(negedge clk);
                cnt++;
            end
        end
        chk({name, "_latency"}, cnt, exp_lat);
        chk({name, "_done"}, {31'd0, bus.classify_done}, 32'd1);
        chk({name, "_busy_in_done"}, {31'd0, bus.busy}, 32'd1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk({name, "_pred"}, {28'd0, bus.pred_class}, {28'd0, r[SCORE_W +: CLASS_W]});
            chk({name, "_score"}, {25'd0, bus.best_score}, {25'd0, r[SCORE_W-1:0]});
        end else begin
            chk({name, "_scoreboard_empty"}, 32'd1, 32'd0);
        end
        @(negedge clk);
        chk({name, "_done_one_cycle"}, {31'd0, bus.classify_done}, 32'd0);
        chk({name, "_idle_after"}, {31'd0, bus.busy}, 32'd0);
        chk({name, "_pred_held"}, {28'd0, bus.pred_class}, {28'd0, v.pred});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        hv_t enc20;
        hv_t enc40;
        hv_t ones;
        hv_t t;
        int  busy_cnt;
        int  done_cnt;

        enc20 = {HV_DIM{1'b0}};
        enc20[19:0] = {20{1'b1}};
        enc40 = {HV_DIM{1'b0}};
        enc40[39:0] = {40{1'b1}};
        ones = {HV_DIM{1'b1}};

        // Exact match on class 3, all others disjoint from the query.
        vecs[0].enc = enc20;
        for (int i = 0; i < NUM_CLASSES; i++) vecs[0].cls[i] = rand_hv() & ~enc20;
        vecs[0].cls[3] = enc20;
        vecs[0].pred = 4'd3;
        vecs[0].score = 7'd20;

        // Tie at 12 between classes 2 and 7; others overlap exactly 5.
        vecs[1].enc = enc40;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            t = rand_hv() & ~enc40;
            t[34:30] = 5'b11111;
            vecs[1].cls[i] = t;
        end
        t = rand_hv() & ~enc40;
        t[11:0] = {12{1'b1}};
        vecs[1].cls[2] = t;
        t = rand_hv() & ~enc40;
        t[23:12] = {12{1'b1}};
        vecs[1].cls[7] = t;
        vecs[1].pred = 4'd2;
        vecs[1].score = 7'd12;

        // Zero query.
        vecs[2].enc = {HV_DIM{1'b0}};
        for (int i = 0; i < NUM_CLASSES; i++) vecs[2].cls[i] = rand_hv();
        vecs[2].pred = 4'd0;
        vecs[2].score = 7'd0;

        // Full-width score on the last class.
        vecs[3].enc = ones;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            t = rand_hv();
            t[0] = 1'b0;
            vecs[3].cls[i] = t;
        end
        vecs[3].cls[NUM_CLASSES-1] = ones;
        vecs[3].pred = 4'd9;
        vecs[3].score = 7'd80;

        for (int k = 4; k < 6; k++) begin
            vecs[k].enc = rand_hv();
            for (int i = 0; i < NUM_CLASSES; i++) vecs[k].cls[i] = rand_hv();
            {vecs[k].pred, vecs[k].score} = ref_result(vecs[k]);
        end

        bus.en = 1'b1;
        bus.start_classify = 1'b1;
        bus.encoded_hv = enc20;
        for (int i = 0; i < NUM_CLASSES; i++) bus.class_hvs[i] = {HV_DIM{1'b0}};
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.classify_done}, 32'd0);
        chk("reset_pred", {28'd0, bus.pred_class}, 32'd0);
        chk("reset_score", {25'd0, bus.best_score}, 32'd0);
        rst = 1'b0;
        bus.start_classify = 1'b0;
        @(negedge clk);
        chk("reset_no_scan", {31'd0, bus.busy}, 32'd0);

        for (int k = 0; k < 6; k++) begin
            run_vec(vecs[k], $sformatf("vec%0d", k), 0, NUM_CLASSES + 1);
        end

        // Stall mid-scan plus an ignored start: latency grows by exactly 3.
        run_vec(vecs[0], "stall", 4, NUM_CLASSES + 4);
        busy_cnt = 0;
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.classify_done) done_cnt++;
        end
        chk("stall_no_second_scan", busy_cnt, 0);
        chk("stall_no_second_done", done_cnt, 0);

        // Reset while idx is 5 discards the scan.
        load_vec(vecs[1]);
        bus.start_classify = 1'b1;
        @(negedge clk);
        bus.start_classify = 1'b0;
        repeat (5) @(negedge clk);
        chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_done", {31'd0, bus.classify_done}, 32'd0);
        chk("midrst_pred", {28'd0, bus.pred_class}, 32'd0);
        chk("midrst_score", {25'd0, bus.best_score}, 32'd0);
        run_vec(vecs[0], "after_rst", 0, NUM_CLASSES + 1);

        chk("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
